divmmc_spi_master: RTL and testbench
====================================

Name: divmmc_spi_master

Overview:
Byte-wide SPI initiator (mode 0, MSB first) that drives the SD card's SPI lines (usdCk/usdCs/usdMosi/usdMiso) from the DivMMC port logic inside the zx48 core. It is the master end of the link whose slave end is the sd_card responder or the physical card. A port write starts one 8-bit full-duplex exchange; the received byte is held for a later port read. A chip-select register drives card CS.

Parameters:
CLKDIV, 2, clock cycles per SCK half-period (min 1); one byte takes 16*CLKDIV cycles.

Ports:
clock  in  1  system clock (clk_sys, 56 MHz)
reset  in  1  asynchronous, active-high reset
cs_wr  in  1  one-cycle strobe: load cs_d into the CS register
cs_d   in  1  new CS level (0 = card selected)
tx_wr  in  1  one-cycle strobe: start a transfer of tx_d
tx_d   in  8  byte to send
rx_rd  in  1  one-cycle strobe: CPU read of rx_q (used only with SPI_AUTOREAD_EN)
rx_q   out 8  last received byte
busy   out 1  transfer in progress
done   out 1  one-cycle pulse: transfer finished, rx_q updated
usdCk  out 1  SPI clock
usdCs  out 1  SPI chip select, active low
usdMosi out 1 SPI data out
usdMiso in  1  SPI data in

Behaviour:
- Reset values: usdCk=0, usdCs=1, usdMosi=1, busy=0, done=0, rx_q=8'hFF; FSM in IDLE; divider and bit counters at 0. Reset takes effect immediately, including mid-transfer: the byte is abandoned and rx_q is not updated.
- FSM states:
  - IDLE: usdCk=0, usdMosi holds its last value. tx_wr sampled at edge N moves the FSM to LOW at N+1, with busy=1, usdMosi=tx_d[7] and the shift register loaded with tx_d.
  - LOW: usdCk=0 for CLKDIV cycles, then go to HIGH with usdCk=1 and usdMiso sampled into the shift LSB on that same edge.
  - HIGH: usdCk=1 for CLKDIV cycles. After the 8th HIGH, go to IDLE with usdCk=0, busy=0, done=1 for one cycle, and rx_q = received byte, all on the same edge. Otherwise go to LOW with usdMosi = next bit.
- Timing: busy is high for exactly 16*CLKDIV cycles. Bit order is MSB first. MISO is sampled on the rising SCK edge; MOSI changes only while SCK is low.
- tx_wr while busy: ignored. There is no queue and the current transfer is unaffected.
- CS register:
  - cs_wr in IDLE: usdCs = cs_d on the next edge.
  - cs_wr while busy: value held pending and applied on the edge busy falls. CS never toggles mid-byte. A later cs_wr overwrites the pending value.
  - cs_wr and tx_wr in the same IDLE cycle: both take effect on the next edge. CS is therefore valid CLKDIV cycles before the first rising SCK edge.
- Transfers run regardless of the usdCs level; 0xFF clocking with CS high is legal for card init.
- rx_q changes only on the done edge.

Optional Feature:
SPI_AUTOREAD_EN
- Defined: an rx_rd sampled in IDLE starts a transfer with tx_d forced to 8'hFF, timed exactly like tx_wr. rx_q still presents the old byte during that read cycle. rx_rd while busy is ignored. If rx_rd and tx_wr are both sampled in IDLE, tx_wr wins and tx_d is sent.
- Not defined: rx_rd has no effect. Reads never start transfers.

Test Plan:
- Reset, then CLKDIV=2, cs_wr with cs_d=0, then tx_wr with tx_d=8'hA5 and usdMiso driven by a slave returning 8'h3C -> usdCs=0 one cycle after cs_wr; usdMosi bits 1,0,1,0,0,1,0,1 on the rising edges; busy high 32 cycles; done pulses once; rx_q=8'h3C.
- tx_wr with 8'h00 issued mid-transfer of 8'hFF -> second write ignored; exactly 8 SCK rising edges; MOSI stays 1 throughout.
- cs_wr with cs_d=1 at cycle 10 of a 32-cycle transfer -> usdCs stays 0 until the edge busy falls, then goes 1.
- Async reset asserted at bit 4 -> usdCk=0, usdCs=1, busy=0 immediately; rx_q=8'hFF; no done pulse.
- CLKDIV=1, tx_wr with 8'h81 and MISO tied 1 -> busy 16 cycles; rx_q=8'hFF; SCK period 2 cycles.
- With SPI_AUTOREAD_EN: rx_rd in IDLE -> MOSI sends 8'hFF and done follows 16*CLKDIV cycles later. Without the macro: rx_rd -> busy stays 0.

Source files
------------

// File: rtl/divmmc_spi_master_if.sv
// CPU-port side bundle of the DivMMC SPI master.
// Optional feature macro used by the master: SPI_AUTOREAD_EN.
interface divmmc_spi_master_if;
  logic       cs_wr;
  logic       cs_d;
  logic       tx_wr;
  logic [7:0] tx_d;
  logic       rx_rd;
  logic [7:0] rx_q;
  logic       busy;
  logic       done;

  modport master (
    output cs_wr, cs_d, tx_wr, tx_d, rx_rd,
    input  rx_q, busy, done
  );

  modport slave (
    input  cs_wr, cs_d, tx_wr, tx_d, rx_rd,
    output rx_q, busy, done
  );
endinterface

// File: rtl/divmmc_spi_master.sv
// DivMMC byte-wide SPI master, mode 0, MSB first.
// Optional macro SPI_AUTOREAD_EN: rx_rd in IDLE clocks out 0xFF.
module divmmc_spi_master #(
  parameter int CLKDIV = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  divmmc_spi_master_if.slave         bus,
  output logic                       usdCk,
  output logic                       usdCs,
  output logic                       usdMosi,
  input  logic                       usdMiso
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLKDIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] div_q, div_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    sh_q, sh_n;
  logic [7:0]    rx_r, rx_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          ck_q, ck_n;
  logic          cs_q, cs_n;
  logic          mosi_q, mosi_n;
  logic          pend_q, pend_n;
  logic          pd_q, pd_n;
  logic          start;
  logic [7:0]    start_d;

  // Transfer request decode: a port write, or an auto-read.
`ifdef SPI_AUTOREAD_EN
  assign start   = bus.tx_wr | bus.rx_rd;
  assign start_d = bus.tx_wr ? bus.tx_d : 8'hFF;
`else
  logic unused_rd;
  assign unused_rd = bus.rx_rd;
  assign start     = bus.tx_wr;
  assign start_d   = bus.tx_d;
`endif

  // Next-state and datapath for the SCK sequencer and CS register.
  always_comb begin
    state_n = state;
    div_n   = div_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    rx_n    = rx_r;
    busy_n  = busy_q;
    done_n  = 1'b0;
    ck_n    = ck_q;
    cs_n    = cs_q;
    mosi_n  = mosi_q;
    pend_n  = pend_q;
    pd_n    = pd_q;

    if (bus.cs_wr) begin
      if (state == IDLE) begin
        cs_n = bus.cs_d;
      end else begin
        pend_n = 1'b1;
        pd_n   = bus.cs_d;
      end
    end

    unique case (state)
      IDLE: begin
        ck_n = 1'b0;
        if (start) begin
          state_n = LOW;
          busy_n  = 1'b1;
          mosi_n  = start_d[7];
          sh_n    = start_d;
          div_n   = '0;
          bit_n   = '0;
        end
      end
      LOW: begin
        if (div_q == LAST) begin
          state_n = HIGH;
          ck_n    = 1'b1;
          sh_n    = {sh_q[6:0], usdMiso};
          div_n   = '0;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_q == LAST) begin
          div_n = '0;
          ck_n  = 1'b0;
          if (bit_q == 3'd7) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            rx_n    = sh_q;
            bit_n   = '0;
            pend_n  = 1'b0;
            if (bus.cs_wr) begin
              cs_n = bus.cs_d;
            end else if (pend_q) begin
              cs_n = pd_q;
            end
          end else begin
            state_n = LOW;
            mosi_n  = sh_q[7];
            bit_n   = bit_q + 1'b1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any byte in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      rx_r   <= 8'hFF;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ck_q   <= 1'b0;
      cs_q   <= 1'b1;
      mosi_q <= 1'b1;
      pend_q <= 1'b0;
      pd_q   <= 1'b1;
    end else begin
      state  <= state_n;
      div_q  <= div_n;
      bit_q  <= bit_n;
      sh_q   <= sh_n;
      rx_r   <= rx_n;
      busy_q <= busy_n;
      done_q <= done_n;
      ck_q   <= ck_n;
      cs_q   <= cs_n;
      mosi_q <= mosi_n;
      pend_q <= pend_n;
      pd_q   <= pd_n;
    end
  end

  assign bus.rx_q = rx_r;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign usdCk    = ck_q;
  assign usdCs    = cs_q;
  assign usdMosi  = mosi_q;

endmodule

// File: tb/tb_divmmc_spi_master.sv
// Bench for divmmc_spi_master: CLKDIV=2 and CLKDIV=1 instances.
// Scoreboard of expected rx/mosi bytes, popped on done.
`timescale 1ns/1ps
module tb_divmmc_spi_master;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  divmmc_spi_master_if bus_a ();
  divmmc_spi_master_if bus_b ();

  logic ck_a, cs_a, mo_a, mi_a;
  logic ck_b, cs_b, mo_b, mi_b;

  divmmc_spi_master #(.CLKDIV(2)) dut_a (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_a),
    .usdCk   (ck_a),
    .usdCs   (cs_a),
    .usdMosi (mo_a),
    .usdMiso (mi_a)
  );

  divmmc_spi_master #(.CLKDIV(1)) dut_b (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_b),
    .usdCk   (ck_b),
    .usdCs   (cs_b),
    .usdMosi (mo_b),
    .usdMiso (mi_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mo;
  } exp_t;
  exp_t sb_a[$];

  // slave model A: mode 0, shifts out slv_a MSB first
  logic [7:0] slv_a = 8'hFF;
  int fall_a = 0, rise_a = 0;
  int fb_a = 0, rb_a = 0;
  logic [7:0] msh_a = 8'h00;
  int d8_a;
  assign d8_a = fall_a - fb_a;
  assign mi_a = (d8_a < 8) ? slv_a[3'(7 - d8_a)] : 1'b1;

  always @(negedge ck_a) fall_a++;
  always @(posedge ck_a) begin
    rise_a++;
    msh_a = {msh_a[6:0], mo_a};
  end

  int bcnt_a = 0, dcnt_a = 0, cshb_a = 0, mlow_a = 0;
  int bb_a = 0, db_a = 0;
  always @(negedge clock) begin
    if (bus_a.busy) bcnt_a++;
    if (bus_a.done) dcnt_a++;
    if (bus_a.busy && cs_a) cshb_a++;
    if (bus_a.busy && !mo_a) mlow_a++;
  end

  // instance B: MISO tied high
  assign mi_b = 1'b1;
  int rise_b = 0, bcnt_b = 0;
  logic [7:0] msh_b = 8'h00;
  longint last_b = 0, per_b = 0;
  always @(posedge ck_b) begin
    rise_b++;
    msh_b = {msh_b[6:0], mo_b};
    per_b = $time - last_b;
    last_b = $time;
  end
  always @(negedge clock) if (bus_b.busy) bcnt_b++;

  task automatic start_a(input logic [7:0] tx,
                         input logic [7:0] slv);
    exp_t e;
    slv_a = slv;
    fb_a  = fall_a;
    rb_a  = rise_a;
    bb_a  = bcnt_a;
    db_a  = dcnt_a;
    e.rx  = slv;
    e.mo  = tx;
    sb_a.push_back(e);
    bus_a.tx_d  = tx;
    bus_a.tx_wr = 1'b1;
    @(negedge clock);
    bus_a.tx_wr = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int bound);
    exp_t e;
    int n = 0;
    while (!bus_a.done && n < bound) begin
      @(negedge clock);
      n++;
    end
    if (!bus_a.done) begin
      check({tag, "_timeout"}, 32'(bus_a.done), 32'd1);
      if (sb_a.size() > 0) void'(sb_a.pop_front());
    end else begin
      e = sb_a.pop_front();
      check({tag, "_rx"}, 32'(bus_a.rx_q), 32'(e.rx));
      check({tag, "_mosi"}, 32'(msh_a), 32'(e.mo));
      check({tag, "_rises"}, 32'(rise_a - rb_a), 32'd8);
      @(negedge clock);
      check({tag, "_busy"}, 32'(bcnt_a - bb_a), 32'd32);
      check({tag, "_dones"}, 32'(dcnt_a - db_a), 32'd1);
    end
  endtask

  initial begin
    int n;
    int mb, cb;
    reset = 1'b1;
    bus_a.cs_wr = 0; bus_a.cs_d = 1; bus_a.tx_wr = 0;
    bus_a.tx_d = 0;  bus_a.rx_rd = 0;
    bus_b.cs_wr = 0; bus_b.cs_d = 1; bus_b.tx_wr = 0;
    bus_b.tx_d = 0;  bus_b.rx_rd = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_ck", 32'(ck_a), 32'd0);
    check("rst_cs", 32'(cs_a), 32'd1);
    check("rst_mosi", 32'(mo_a), 32'd1);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_rxq", 32'(bus_a.rx_q), 32'hFF);

    // select card
    bus_a.cs_d  = 1'b0;
    bus_a.cs_wr = 1'b1;
    @(negedge clock);
    bus_a.cs_wr = 1'b0;
    check("cs_sel", 32'(cs_a), 32'd0);

    // basic exchange A5 out, 3C in
    start_a(8'hA5, 8'h3C);
    check("a5_busy1", 32'(bus_a.busy), 32'd1);
    check("a5_mosi7", 32'(mo_a), 32'd1);
    wait_done_a("a5", 100);

    // second write mid-transfer is ignored
    mb = mlow_a;
    start_a(8'hFF, 8'h5A);
    repeat (10) @(negedge clock);
    bus_a.tx_d  = 8'h00;
    bus_a.tx_wr = 1'b1;
    @(negedge clock);
    bus_a.tx_wr = 1'b0;
    wait_done_a("ign", 100);
    check("ign_mosi_low", 32'(mlow_a - mb), 32'd0);
    check("ign_idle", 32'(bus_a.busy), 32'd0);

    // CS write during a transfer is deferred to the end
    cb = cshb_a;
    start_a(8'hC3, 8'h96);
    repeat (9) @(negedge clock);
    bus_a.cs_d  = 1'b1;
    bus_a.cs_wr = 1'b1;
    @(negedge clock);
    bus_a.cs_wr = 1'b0;
    check("csd_mid", 32'(cs_a), 32'd0);
    wait_done_a("csd", 100);
    check("csd_hi_busy", 32'(cshb_a - cb), 32'd0);
    check("csd_after", 32'(cs_a), 32'd1);

    // CS and transfer in the same idle cycle
    bus_a.cs_d  = 1'b0;
    bus_a.cs_wr = 1'b1;
    start_a(8'h6E, 8'hB1);
    bus_a.cs_wr = 1'b0;
    check("cstx_cs", 32'(cs_a), 32'd0);
    check("cstx_busy", 32'(bus_a.busy), 32'd1);
    check("cstx_ck", 32'(ck_a), 32'd0);
    wait_done_a("cstx", 100);

    // async reset in the middle of bit 4
    start_a(8'h5A, 8'hA5);
    n = 0;
    while ((rise_a - rb_a) < 4 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("rst4_reach", 32'(rise_a - rb_a >= 4), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ck", 32'(ck_a), 32'd0);
    check("arst_cs", 32'(cs_a), 32'd1);
    check("arst_busy", 32'(bus_a.busy), 32'd0);
    check("arst_rxq", 32'(bus_a.rx_q), 32'hFF);
    void'(sb_a.pop_front());
    @(negedge clock);
    reset = 1'b0;
    db_a = dcnt_a;
    repeat (40) @(negedge clock);
    check("arst_nodone", 32'(dcnt_a - db_a), 32'd0);
    check("arst_rxq2", 32'(bus_a.rx_q), 32'hFF);
    check("arst_idle", 32'(bus_a.busy), 32'd0);

    // CLKDIV=1, 0x81 out, MISO high
    begin
      int rb, bb;
      rb = rise_b;
      bb = bcnt_b;
      bus_b.tx_d  = 8'h81;
      bus_b.tx_wr = 1'b1;
      @(negedge clock);
      bus_b.tx_wr = 1'b0;
      n = 0;
      while (!bus_b.done && n < 60) begin
        @(negedge clock);
        n++;
      end
      check("b_done", 32'(bus_b.done), 32'd1);
      check("b_rxq", 32'(bus_b.rx_q), 32'hFF);
      check("b_mosi", 32'(msh_b), 32'h81);
      check("b_rises", 32'(rise_b - rb), 32'd8);
      check("b_period", 32'(per_b), 32'd20);
      @(negedge clock);
      check("b_busy", 32'(bcnt_b - bb), 32'd16);
    end

    // read strobe
`ifdef SPI_AUTOREAD_EN
    begin
      exp_t e;
      slv_a = 8'h4D;
      fb_a  = fall_a;
      rb_a  = rise_a;
      bb_a  = bcnt_a;
      db_a  = dcnt_a;
      e.rx  = 8'h4D;
      e.mo  = 8'hFF;
      sb_a.push_back(e);
      bus_a.rx_rd = 1'b1;
      @(negedge clock);
      bus_a.rx_rd = 1'b0;
      check("ard_busy", 32'(bus_a.busy), 32'd1);
      wait_done_a("ard", 100);
    end
`else
    bb_a = bcnt_a;
    bus_a.rx_rd = 1'b1;
    @(negedge clock);
    bus_a.rx_rd = 1'b0;
    repeat (5) @(negedge clock);
    check("rd_nobusy", 32'(bcnt_a - bb_a), 32'd0);
    check("rd_rxq", 32'(bus_a.rx_q), 32'hFF);
`endif

    check("sb_empty", 32'(sb_a.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
